// File: rtl/aes_pkg.sv
// Shared AES constants and the key-stream FSM state encoding.
package aes_pkg;
  localparam int AES_NR             = 10;
  localparam int AES_BLOCK_BYTES    = 16;
  localparam int AES_KEYSTORE_BYTES = (AES_NR + 1) * AES_BLOCK_BYTES;
  localparam int AES_ADDR_W         = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_EMPTY    = 3'd0;
  localparam state_t S_LOAD     = 3'd1;
  localparam state_t S_READY    = 3'd2;
  localparam state_t S_STREAM   = 3'd3;
  localparam state_t S_WAIT_REQ = 3'd4;
endpackage

// File: rtl/aes_key_store.sv
// Round-key byte store: one synchronous write port, one registered read port.
module aes_key_store
  import aes_pkg::*;
#(
  parameter int DEPTH = AES_KEYSTORE_BYTES,
  parameter int AW    = AES_ADDR_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  // Contents are not reset; only the read register is.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/aes_key_stream_ctrl.sv
// Round-key sequencer: byte-serial key load, then per-round byte streaming
// in ascending (encrypt) or descending (decrypt) round order.
module aes_key_stream_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int RIDX_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              keys_loaded,
  input  logic              start,
  input  logic              decrypt,
  input  logic              key_req,
  input  logic              hold,
  output logic              key_valid,
  output logic [7:0]        key_byte,
  output logic [RIDX_W-1:0] round_idx,
  output logic              round_last,
  output logic              busy,
  output logic              done
);
  localparam int AW = AES_ADDR_W;
  localparam int DEPTH = (NR + 1) * AES_BLOCK_BYTES;
  localparam logic [AW-1:0] LAST_WADDR = AW'(DEPTH - 1);
  localparam logic [3:0] LAST_BPTR = 4'(AES_BLOCK_BYTES - 1);

  state_t            state;
  logic [AW-1:0]     wptr, rd_addr;
  logic [RIDX_W-1:0] round, rd_round, final_round;
  logic [3:0]        bptr, rd_bptr;
  logic              dec, loading, we, rd_en, consume, round_end;

  assign loading     = (state == S_EMPTY) || (state == S_LOAD) || (state == S_READY);
  assign load_ready  = loading && !reset;
  assign we          = load_valid && loading;
  assign key_valid   = (state == S_STREAM);
  assign busy        = (state == S_STREAM) || (state == S_WAIT_REQ);
  assign final_round = dec ? '0 : RIDX_W'(NR);
  assign round_idx   = round;
  assign round_last  = key_valid && (round == final_round);
  assign consume     = key_valid && !hold;
  assign round_end   = consume && (bptr == LAST_BPTR);
  assign rd_addr     = AW'(rd_round) * AW'(AES_BLOCK_BYTES) + AW'(rd_bptr);

  // Read address targets the byte to be shown next cycle, so the registered
  // read port lines up with the state transition.
  always_comb begin
    rd_en    = 1'b0;
    rd_round = round;
    rd_bptr  = '0;
    case (state)
      S_READY: if (start && !load_valid) begin
        rd_en    = 1'b1;
        rd_round = decrypt ? RIDX_W'(NR) : '0;
      end
      S_STREAM: if (consume && !round_end) begin
        rd_en   = 1'b1;
        rd_bptr = bptr + 4'd1;
      end
      S_WAIT_REQ: rd_en = key_req;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_EMPTY;
      wptr        <= '0;
      round       <= '0;
      bptr        <= '0;
      dec         <= 1'b0;
      keys_loaded <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_EMPTY, S_LOAD, S_READY: begin
          if (load_valid) begin
            if (wptr == LAST_WADDR) begin
              state       <= S_READY;
              wptr        <= '0;
              keys_loaded <= 1'b1;
            end else begin
              state       <= S_LOAD;
              wptr        <= wptr + AW'(1);
              keys_loaded <= 1'b0;
            end
          end else if (state == S_READY && start) begin
            dec   <= decrypt;
            round <= rd_round;
            bptr  <= '0;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (round_end) begin
            bptr <= '0;
            if (round == final_round) begin
              done  <= 1'b1;
              state <= S_READY;
            end else begin
              round <= dec ? round - RIDX_W'(1) : round + RIDX_W'(1);
              state <= S_WAIT_REQ;
            end
          end else if (consume) begin
            bptr <= bptr + 4'd1;
          end
        end
        S_WAIT_REQ: if (key_req) state <= S_STREAM;
        default: state <= S_EMPTY;
      endcase
    end
  end

  aes_key_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (wptr),
    .wdata (load_byte),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (key_byte)
  );
endmodule
